// File: rtl/mem_responder.sv
//==============================================================================
// Module      : mem_responder
// Description : Slave end of the MAR/MDR memory interface. It services Read and
//               Write requests against an internal word RAM after programmable
//               wait states, and completes each transfer with a four-phase Done.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_responder #(
    parameter int ADDR_BITS   = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        Read,
    input  logic        Write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] Mdatain,
    output logic        Done,
    output logic        Busy,
    output logic        err
);

    localparam int         c_DEPTH = 1 << ADDR_BITS;
    localparam logic [3:0] c_WAIT  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                 r_state;
    logic [3:0]             r_cnt;
    logic [31:0]            r_addr;
    logic [31:0]            r_wdata;
    logic                   r_rd;
    logic                   r_wr;
    logic [31:0]            r_mem [c_DEPTH];

    logic [ADDR_BITS-1:0]   w_idx;
    logic                   w_in_range;
    logic                   w_illegal;
    logic                   w_commit;
    logic                   w_mem_we;

    assign w_idx      = r_addr[ADDR_BITS-1:0];
    assign w_in_range = ((r_addr >> ADDR_BITS) == 32'd0);
    assign w_illegal  = r_rd & r_wr;
    assign w_commit   = (r_state == S_WAIT) && (r_cnt == 4'd0);
    // The FSM is forced to IDLE by clr, so an aborted write never commits.
    assign w_mem_we   = w_commit && r_wr && !r_rd && w_in_range;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            Mdatain <= 32'd0;
            Done    <= 1'b0;
            Busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Read || Write) begin
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_rd    <= Read;
                        r_wr    <= Write;
                        r_cnt   <= c_WAIT;
                        Busy    <= 1'b1;
                        r_state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        if (w_illegal) begin
                            err <= 1'b1;
                        end else if (!w_in_range) begin
                            err <= 1'b1;
                            if (r_rd) begin
                                Mdatain <= 32'd0;
                            end
                        end else begin
                            err <= 1'b0;
                            if (r_rd) begin
                                Mdatain <= r_mem[w_idx];
                            end
                        end
                        Done    <= 1'b1;
                        r_state <= S_HOLD;
                    end
                end

                S_HOLD: begin
                    // Requests must drop before a new transfer can start.
                    if (!Read && !Write) begin
                        Done    <= 1'b0;
                        Busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    Done    <= 1'b0;
                    Busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
//==============================================================================
// Module      : tb_mem_responder
// Description : Randomized self-checking bench for mem_responder with a
//               word-array reference model of the RAM and MDR.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_responder;

    localparam int ADDR_BITS   = 9;
    localparam int WAIT_CYCLES = 2;
    localparam int DEPTH       = 1 << ADDR_BITS;

    logic        clk = 1'b0;
    logic        clr;
    logic        Read;
    logic        Write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] Mdatain;
    logic        Done;
    logic        Busy;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_ram [DEPTH];
    logic [31:0] m_mdr;

    mem_responder #(
        .ADDR_BITS   (ADDR_BITS),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .Read    (Read),
        .Write   (Write),
        .addr    (addr),
        .wdata   (wdata),
        .Mdatain (Mdatain),
        .Done    (Done),
        .Busy    (Busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One full transfer: request, wait for Done, compare against the model,
    // optionally hold the request for extra edges, then drop it.
    task automatic do_xfer(input bit rd, input bit wr, input logic [31:0] a,
                           input logic [31:0] d, input int hold, input bit drop);
        int  n;
        bit  exp_err;
        @(negedge clk);
        Read  = rd;
        Write = wr;
        addr  = a;
        wdata = d;
        @(posedge clk); #1;
        n = 1;
        check("busy_accept", {31'd0, Busy}, 32'd1);
        check("done_accept", {31'd0, Done}, 32'd0);
        addr  = $urandom;
        wdata = $urandom;
        while (!Done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, WAIT_CYCLES + 2);

        if (rd && wr) begin
            exp_err = 1'b1;
        end else if (a >= DEPTH) begin
            exp_err = 1'b1;
            if (rd) m_mdr = 32'd0;
        end else begin
            exp_err = 1'b0;
            if (rd) m_mdr = m_ram[a];
            else    m_ram[a] = d;
        end
        check("err", {31'd0, err}, {31'd0, exp_err});
        check("mdatain", Mdatain, m_mdr);
        check("busy_hold", {31'd0, Busy}, 32'd1);

        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_done", {31'd0, Done}, 32'd1);
            check("hold_busy", {31'd0, Busy}, 32'd1);
            check("hold_mdatain", Mdatain, m_mdr);
        end

        if (drop) begin
            @(negedge clk);
            Read  = 1'b0;
            Write = 1'b0;
            @(posedge clk); #1;
            check("drop_done", {31'd0, Done}, 32'd0);
            check("drop_busy", {31'd0, Busy}, 32'd0);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 3) == 0)
            return $urandom | (32'd1 << $urandom_range(ADDR_BITS, 31));
        return 32'($urandom_range(0, DEPTH - 1));
    endfunction

    initial begin
        int op;
        clr   = 1'b1;
        Read  = 1'b0;
        Write = 1'b0;
        addr  = 32'd0;
        wdata = 32'd0;
        m_mdr = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mdatain", Mdatain, 32'd0);
        check("rst_done", {31'd0, Done}, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        clr = 1'b0;

        // Fill the RAM so every later read has a known expectation.
        for (int i = 0; i < DEPTH; i++)
            do_xfer(1'b0, 1'b1, 32'(i), (32'(i) * 32'h9E3779B9) ^ 32'hA5A50000, 0, 1'b1);

        do_xfer(1'b0, 1'b1, 32'h5, 32'hDEADBEEF, 0, 1'b1);
        do_xfer(1'b1, 1'b0, 32'h5, 32'h0, 0, 1'b0);
        check("rd_deadbeef", Mdatain, 32'hDEADBEEF);

        // Asynchronous reset between edges while Mdatain is nonzero.
        #2;
        clr = 1'b1;
        #1;
        check("arst_mdatain", Mdatain, 32'd0);
        check("arst_done", {31'd0, Done}, 32'd0);
        check("arst_busy", {31'd0, Busy}, 32'd0);
        check("arst_err", {31'd0, err}, 32'd0);
        m_mdr = 32'd0;
        Read  = 1'b0;
        @(negedge clk);
        clr = 1'b0;

        do_xfer(1'b1, 1'b0, 32'h5, 32'h0, 0, 1'b1);
        do_xfer(1'b1, 1'b0, 32'h200, 32'h0, 0, 1'b1);
        check("oor_rd_zero", Mdatain, 32'd0);
        do_xfer(1'b0, 1'b1, 32'h200, 32'hFFFF0000, 0, 1'b1);
        do_xfer(1'b1, 1'b0, 32'h0, 32'h0, 0, 1'b1);
        do_xfer(1'b1, 1'b0, 32'h3, 32'h0, 0, 1'b1);
        do_xfer(1'b1, 1'b1, 32'h7, 32'h0BADF00D, 0, 1'b1);
        do_xfer(1'b1, 1'b0, 32'h7, 32'h0, 0, 1'b1);

        // Reset during the wait states of a write must discard it.
        @(negedge clk);
        Write = 1'b1;
        addr  = 32'hA;
        wdata = 32'h12345678;
        @(posedge clk); #1;
        @(posedge clk); #1;
        clr = 1'b1;
        #1;
        check("midrst_busy", {31'd0, Busy}, 32'd0);
        check("midrst_done", {31'd0, Done}, 32'd0);
        m_mdr = 32'd0;
        Write = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk); #1;
        check("midrst_idle", {31'd0, Busy}, 32'd0);
        do_xfer(1'b1, 1'b0, 32'hA, 32'h0, 0, 1'b1);

        // Held request must not retrigger; a reassertion starts a new transfer.
        do_xfer(1'b1, 1'b0, 32'h11, 32'h0, 5, 1'b1);
        do_xfer(1'b1, 1'b0, 32'h12, 32'h0, 0, 1'b1);

        for (int t = 0; t < 300; t++) begin
            op = $urandom_range(0, 9);
            do_xfer(op < 5 || op == 9, op >= 5, rand_addr(), $urandom,
                    $urandom_range(0, 2), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the CPU datapath's MAR/MDR memory interface. It accepts Read/Write requests carrying an address (from MAR) and write data (from MDR), and services them against an internal word-addressed RAM after a programmable wait-state count. It returns read data on Mdatain, which feeds the MDR, and completes each transfer with a four-phase Done handshake. It is the slave end of the memory interface that the control sequencer and datapath drive.

Parameters:
ADDR_BITS, 9, number of word-address bits decoded; RAM holds 2**ADDR_BITS 32-bit words
WAIT_CYCLES, 2, wait states inserted between request acceptance and commit (0..15 legal)

Ports:
clk  input  1  system clock, rising-edge active
clr  input  1  asynchronous active-high reset
Read  input  1  read request, level, held high until Done observed
Write  input  1  write request, level, held high until Done observed
addr  input  32  word address (MAR output); bits [ADDR_BITS-1:0] index the RAM
wdata  input  32  write data (MDR output)
Mdatain  output  32  read data to MDR; registered
Done  output  1  transfer complete, four-phase acknowledge
Busy  output  1  high from acceptance until return to IDLE
err  output  1  error flag for the completed transfer, valid while Done=1

Behaviour:
- Interface: one clock (clk); reset clr is asynchronous and active-high.
- Reset (clr=1, asynchronous):
  - State goes to IDLE.
  - Mdatain=0, Done=0, Busy=0, err=0, wait counter=0.
  - RAM contents are not cleared.
  - Reset mid-transfer aborts it. An uncommitted write never reaches the RAM.
- FSM states:
  - IDLE: if Read|Write is high at a rising edge, latch addr, wdata and op, then go to WAIT with cnt=WAIT_CYCLES and Busy=1.
  - WAIT: each edge with cnt!=0 decrements cnt. The edge with cnt==0 performs the commit and goes to HOLD.
  - HOLD: Done=1 and Busy=1. When Read and Write are both low at an edge, go to IDLE with Done=0 and Busy=0.
- Latency: a request accepted at edge e0 commits at edge e0+WAIT_CYCLES+1. Done is high after that edge.
  - WAIT_CYCLES=0 gives a 1-cycle commit.
- Commit actions:
  - Read, in range: Mdatain <= RAM[addr[ADDR_BITS-1:0]], err=0.
  - Write, in range: RAM[index] <= latched wdata, err=0, Mdatain unchanged.
  - Out of range (latched addr[31:ADDR_BITS] != 0): no RAM access, Mdatain <= 0 for reads (unchanged for writes), err=1.
  - Read and Write both high at acceptance: illegal. No RAM access, Mdatain unchanged, err=1.
- Request changes after acceptance (addr, wdata, op) are ignored; the latched values are used.
- err holds its value until the next commit or reset.
- Mdatain holds its last read value through IDLE and all write transfers.
- Requests are never accepted outside IDLE. A request still high in HOLD does not retrigger; a new transfer needs the request to deassert and reassert.
- Back-to-back throughput: the fastest repeat is request-drop at the HOLD edge, then reassert accepted at the next IDLE edge.

Test Plan:
- Reset check: assert clr asynchronously between edges -> Mdatain=0, Done=0, Busy=0, err=0 immediately, without waiting for a clock edge.
- Write then read (WAIT_CYCLES=2):
  - Write addr=0x05, wdata=0xDEADBEEF -> Done rises 3 edges after acceptance, err=0.
  - Drop Write, then Read addr=0x05 -> Mdatain=0xDEADBEEF when Done=1.
- Out-of-range read: addr=0x00000200 (ADDR_BITS=9) -> err=1, Mdatain=0x00000000, Done=1.
- Out-of-range write: addr=0x00000200 -> err=1 and RAM[0] is unchanged.
- Illegal request: Read=1 and Write=1 at addr=0x07 -> err=1, RAM[7] unchanged, Mdatain keeps its previous value.
- Reset mid-write: Write addr=0x0A, wdata=0x12345678, pulse clr during WAIT, then read 0x0A -> the old content is returned, not 0x12345678. FSM must be in IDLE with Busy=0 after reset.
- Handshake hold: keep Read high for 5 edges after Done -> Done stays 1, no second access, Busy=1.
  - Drop Read -> next edge gives Done=0, Busy=0.
  - Re-assert Read -> new transfer accepted.
